// File: rtl/regfile_debug_port.sv
// Debug initiator for the integer register file: single read/write, full dump and
// full clear, sharing the register-file write port behind the core writeback path.
module regfile_debug_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  input  logic              core_RegWrite,
  input  logic [ADDR_W-1:0] core_WriteRegister,
  input  logic [DATA_W-1:0] core_WriteData,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] ReadRegister,
  input  logic [DATA_W-1:0] ReadData
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DUMP_RD, DUMP_RSP, CLEAR, RESP} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [ADDR_W:0]     cnt, cnt_nxt;
  logic [ADDR_W-1:0]   rsp_addr_nxt;
  logic [DATA_W-1:0]   rsp_data_nxt;
  logic                dbg_we;
  logic [ADDR_W-1:0]   dbg_waddr;
  logic [DATA_W-1:0]   dbg_wdata;
  logic [ADDR_W-1:0]   cnt_lo;

  assign cnt_lo = cnt[ADDR_W-1:0];

  // A core write landing in the same cycle as the sample is forwarded, since the
  // register file only shows it on the following cycle.
  function automatic logic [DATA_W-1:0] read_sample(
    input logic [ADDR_W-1:0] idx,
    input logic              c_we,
    input logic [ADDR_W-1:0] c_idx,
    input logic [DATA_W-1:0] c_data,
    input logic [DATA_W-1:0] rf_data
  );
    if (idx == '0)                    return '0;
    else if (c_we && (c_idx == idx))  return c_data;
    else                              return rf_data;
  endfunction

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    cnt_nxt      = cnt;
    rsp_addr_nxt = rsp_addr;
    rsp_data_nxt = rsp_data;
    dbg_we       = 1'b0;
    dbg_waddr    = '0;
    dbg_wdata    = '0;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_last     = 1'b0;
    ReadRegister = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_nxt  = cmd_addr;
          wdata_nxt = cmd_wdata;
          case (cmd_op)
            2'b00:   state_nxt = READ;
            2'b01:   state_nxt = WRITE;
            2'b10: begin
              state_nxt = DUMP_RD;
              cnt_nxt   = '0;
            end
            default: begin
              state_nxt = CLEAR;
              cnt_nxt   = {{ADDR_W{1'b0}}, 1'b1};
            end
          endcase
        end
      end
      READ: begin
        ReadRegister = addr_q;
        rsp_data_nxt = read_sample(addr_q, core_RegWrite, core_WriteRegister,
                                   core_WriteData, ReadData);
        rsp_addr_nxt = addr_q;
        state_nxt    = RESP;
      end
      WRITE: begin
        if (addr_q == '0) begin
          rsp_data_nxt = '0;
          rsp_addr_nxt = '0;
          state_nxt    = RESP;
        end else if (!core_RegWrite) begin
          dbg_we       = 1'b1;
          dbg_waddr    = addr_q;
          dbg_wdata    = wdata_q;
          rsp_data_nxt = wdata_q;
          rsp_addr_nxt = addr_q;
          state_nxt    = RESP;
        end
      end
      DUMP_RD: begin
        ReadRegister = cnt_lo;
        rsp_data_nxt = read_sample(cnt_lo, core_RegWrite, core_WriteRegister,
                                   core_WriteData, ReadData);
        rsp_addr_nxt = cnt_lo;
        state_nxt    = DUMP_RSP;
      end
      DUMP_RSP: begin
        rsp_valid = 1'b1;
        rsp_last  = (cnt == LAST_IDX);
        if (rsp_ready) begin
          if (cnt == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = DUMP_RD;
          end
        end
      end
      CLEAR: begin
        // Core cycles stall the sweep; the counter only advances on a debug write.
        if (!core_RegWrite) begin
          dbg_we    = 1'b1;
          dbg_waddr = cnt_lo;
          dbg_wdata = '0;
          if (cnt == LAST_IDX) begin
            rsp_data_nxt = DATA_W'(LAST_IDX);
            rsp_addr_nxt = '0;
            state_nxt    = RESP;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      rsp_addr <= '0;
      rsp_data <= '0;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      cnt      <= cnt_nxt;
      rsp_addr <= rsp_addr_nxt;
      rsp_data <= rsp_data_nxt;
    end
  end

  assign RegWrite      = core_RegWrite | dbg_we;
  assign WriteRegister = core_RegWrite ? core_WriteRegister : dbg_waddr;
  assign WriteData     = core_RegWrite ? core_WriteData     : dbg_wdata;

endmodule
